// File: rtl/rgmii_ddr_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module : rgmii_tx_pkg
// Brief  : Shared state encodings and control helpers for the RGMII TX DDR path
// Rev    : 1.0  initial release
// ============================================================================
package rgmii_tx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;

    localparam logic CTL_IDLE = 1'b0;

    // RGMII carries TX_ER encoded as EN^ER on the falling half of TX_CTL
    function automatic logic ctl_fall(input logic en, input logic er);
        return en ^ er;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgmii_ddr_tx_serializer_lane_bank.sv
`default_nettype none
// ============================================================================
// Module : ddr_out_lane_bank
// Brief  : Posedge rise/fall staging, negedge fall retime and clock-phase mux
// Rev    : 1.0  initial release
// ============================================================================
module ddr_out_lane_bank #(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_rise,
    input  logic [WIDTH-1:0] i_fall,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_rise_q;
    logic [WIDTH-1:0] r_fall_stage;
    logic [WIDTH-1:0] r_fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise_q     <= RST_VAL;
            r_fall_stage <= RST_VAL;
        end else if (i_ce) begin
            r_rise_q     <= i_rise;
            r_fall_stage <= i_fall;
        end
    end

    // Negedge only retimes the staged value, so it never samples live inputs
    always_ff @(negedge clk) begin
        r_fall_q <= r_fall_stage;
    end

    assign o_q = clk ? r_rise_q : r_fall_q;

endmodule
`default_nettype wire

// File: rtl/rgmii_ddr_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module : rgmii_ddr_tx_serializer
// Brief  : Multi-lane RGMII TX DDR stage with 1G / 10-100 modes and underrun tracking
// Rev    : 1.0  initial release
// ============================================================================
module rgmii_ddr_tx_serializer
    import rgmii_tx_pkg::*;
#(
    parameter int   LANES = 4,
    parameter logic INIT  = 1'b0,
    parameter int   CNT_W = 16
) (
    input  logic               C,
    input  logic               R,
    input  logic               CE,
    input  logic               spd_1g,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*LANES-1:0] in_d,
    input  logic               in_en,
    input  logic               in_er,
    output logic [LANES-1:0]   Q,
    output logic               Q_CTL,
    output logic               underrun,
    output logic [CNT_W-1:0]   underrun_cnt
);

    localparam logic [LANES:0] c_idle_slot = {CTL_IDLE, {LANES{INIT}}};

    logic               r_mode;
    logic [1:0]         r_state;
    logic [2*LANES-1:0] r_hold_d;
    logic               r_hold_en;
    logic               r_hold_er;
    logic               r_hold_vld;
    logic               r_last_en;
    logic               r_urun_pend;
    logic               r_underrun;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_open;
    logic               w_accept;
    logic               w_miss;
    logic               w_mode_upd;
    logic               w_mode_nxt;
    logic [1:0]         w_state_nxt;
    logic [LANES-1:0]   w_lo;
    logic [LANES-1:0]   w_hi;
    logic               w_cr;
    logic               w_cf;
    logic [LANES:0]     w_rise;
    logic [LANES:0]     w_fall;
    logic [LANES:0]     w_q;

    // A slot is open whenever the next output word could come from the input
    assign w_open     = r_mode | (r_state != ST_LO);
    assign in_ready   = CE & ~R & w_open;
    assign w_accept   = in_valid & in_ready;
    assign w_miss     = CE & ~R & w_open & ~in_valid & r_last_en;
    assign w_mode_upd = r_mode ? ~r_last_en : (r_state == ST_IDLE);
    assign w_mode_nxt = w_mode_upd ? spd_1g : r_mode;

    assign w_lo = r_hold_d[LANES-1:0];
    assign w_hi = r_hold_d[2*LANES-1:LANES];
    assign w_cr = r_hold_en;
    assign w_cf = ctl_fall(r_hold_en, r_hold_er);

    always_comb begin
        w_rise = c_idle_slot;
        w_fall = c_idle_slot;
        if (r_mode) begin
            if (r_hold_vld) begin
                w_rise = {w_cr, w_lo};
                w_fall = {w_cf, w_hi};
            end
        end else begin
            case (r_state)
                ST_LO: begin
                    w_rise = {w_cr, w_lo};
                    w_fall = {w_cf, w_lo};
                end
                ST_HI: begin
                    w_rise = {w_cr, w_hi};
                    w_fall = {w_cf, w_hi};
                end
                default: ;
            endcase
        end
    end

    // The FSM only runs in 10/100; a word accepted on a 1G->10/100 switch starts in LO
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (!w_mode_nxt) begin
            if (!r_mode && (r_state == ST_LO)) begin
                w_state_nxt = ST_HI;
            end else if (w_accept) begin
                w_state_nxt = ST_LO;
            end
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            r_mode      <= spd_1g;
            r_state     <= ST_IDLE;
            r_hold_d    <= '0;
            r_hold_en   <= 1'b0;
            r_hold_er   <= 1'b0;
            r_hold_vld  <= 1'b0;
            r_last_en   <= 1'b0;
            r_urun_pend <= 1'b0;
            r_underrun  <= 1'b0;
            r_cnt       <= '0;
        end else if (!CE) begin
            r_underrun <= 1'b0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_state    <= w_state_nxt;
            r_hold_vld <= w_accept;
            if (w_accept) begin
                r_hold_d  <= in_d;
                r_hold_en <= in_en;
                r_hold_er <= in_er;
                r_last_en <= in_en;
            end else if (w_open) begin
                r_last_en <= 1'b0;
            end
            // Delay the flag one stage so it lines up with the idle slot on Q
            r_urun_pend <= w_miss;
            r_underrun  <= r_urun_pend;
            if (r_urun_pend && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    ddr_out_lane_bank #(
        .WIDTH   (LANES + 1),
        .RST_VAL (c_idle_slot)
    ) u_lane_bank (
        .clk    (C),
        .rst    (R),
        .i_ce   (CE),
        .i_rise (w_rise),
        .i_fall (w_fall),
        .o_q    (w_q)
    );

    assign Q            = w_q[LANES-1:0];
    assign Q_CTL        = w_q[LANES];
    assign underrun     = r_underrun;
    assign underrun_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rgmii_ddr_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_rgmii_ddr_tx_serializer
// Brief  : Slot-queue reference model with directed and randomized stimulus
// Rev    : 1.0  initial release
// ============================================================================
module tb_rgmii_ddr_tx_serializer;

    localparam int   LANES = 4;
    localparam logic INIT  = 1'b1;
    localparam int   CNT_W = 2;
    localparam logic [LANES-1:0] IDLE_Q = {LANES{INIT}};
    localparam int   CNT_MAX = (1 << CNT_W) - 1;

    logic               C = 1'b0;
    logic               R, CE, spd_1g, in_valid, in_en, in_er;
    logic [2*LANES-1:0] in_d;
    logic               in_ready, Q_CTL, underrun;
    logic [LANES-1:0]   Q;
    logic [CNT_W-1:0]   underrun_cnt;

    rgmii_ddr_tx_serializer #(
        .LANES (LANES),
        .INIT  (INIT),
        .CNT_W (CNT_W)
    ) dut (
        .C            (C),
        .R            (R),
        .CE           (CE),
        .spd_1g       (spd_1g),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_d         (in_d),
        .in_en        (in_en),
        .in_er        (in_er),
        .Q            (Q),
        .Q_CTL        (Q_CTL),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 C = ~C;

    // Each accepted word becomes one (1G) or two (10/100) output slots
    typedef struct {
        logic [LANES-1:0] r;
        logic [LANES-1:0] f;
        logic             cr;
        logic             cf;
    } slot_t;

    slot_t sq[$];
    bit    m_mode, m_last_en, m_prev;
    int    m_cnt;
    logic [LANES-1:0] e_rise, e_fall;
    logic  e_cr, e_cf, e_urun;

    logic [LANES-1:0] obs_rise, obs_fall;
    logic  obs_cr, obs_cf, obs_urun, obs_ready;
    logic [CNT_W-1:0] obs_cnt;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (R == 1'b0) && (CE == 1'b1) && (m_mode || (sq.size() <= 1));
    endfunction

    task automatic model_step();
        slot_t s, s2;
        bit rdy, acc, upd, nm;
        if (R) begin
            sq.delete();
            m_mode = spd_1g; m_last_en = 0; m_prev = 0; m_cnt = 0;
            e_rise = IDLE_Q; e_fall = IDLE_Q; e_cr = 0; e_cf = 0; e_urun = 0;
        end else if (!CE) begin
            e_urun = 0;
        end else begin
            rdy = model_ready();
            acc = in_valid && rdy;
            upd = m_mode ? !m_last_en : (sq.size() == 0);
            nm  = upd ? spd_1g : m_mode;
            if (sq.size() > 0) begin
                s = sq.pop_front();
                e_rise = s.r; e_fall = s.f; e_cr = s.cr; e_cf = s.cf;
                e_urun = 0;
                m_prev = s.cr;
            end else begin
                e_rise = IDLE_Q; e_fall = IDLE_Q; e_cr = 0; e_cf = 0;
                e_urun = m_prev;
                if (m_prev && m_cnt < CNT_MAX) m_cnt++;
                m_prev = 0;
            end
            if (acc) begin
                s.cr = in_en; s.cf = in_en ^ in_er;
                s2 = s;
                if (nm) begin
                    s.r = in_d[LANES-1:0]; s.f = in_d[2*LANES-1:LANES];
                    sq.push_back(s);
                end else begin
                    s.r  = in_d[LANES-1:0];       s.f  = in_d[LANES-1:0];
                    s2.r = in_d[2*LANES-1:LANES]; s2.f = in_d[2*LANES-1:LANES];
                    sq.push_back(s);
                    sq.push_back(s2);
                end
                m_last_en = in_en;
            end else if (rdy) begin
                m_last_en = 0;
            end
            m_mode = nm;
        end
    endtask

    // One clock: ready check before the edge, rise half after it, fall half after negedge
    task automatic cycle();
        #1;
        obs_ready = in_ready;
        chk("in_ready", in_ready, model_ready());
        @(posedge C);
        model_step();
        #3;
        obs_rise = Q; obs_cr = Q_CTL; obs_urun = underrun; obs_cnt = underrun_cnt;
        chk("q_rise", Q, e_rise);
        chk("ctl_rise", Q_CTL, e_cr);
        chk("underrun", underrun, e_urun);
        chk("underrun_cnt", underrun_cnt, m_cnt[CNT_W-1:0]);
        #5;
        obs_fall = Q; obs_cf = Q_CTL;
        chk("q_fall", Q, e_fall);
        chk("ctl_fall", Q_CTL, e_cf);
    endtask

    task automatic send(input logic [2*LANES-1:0] d, input logic en, input logic er);
        in_valid = 1'b1; in_d = d; in_en = en; in_er = er;
    endtask

    initial begin
        R = 1; CE = 1; spd_1g = 1; in_valid = 0; in_d = '0; in_en = 0; in_er = 0;
        cycle(); cycle();
        chk("rst_rise", obs_rise, IDLE_Q);
        chk("rst_fall", obs_fall, IDLE_Q);
        chk("rst_ctl", {obs_cr, obs_cf}, 2'b00);
        R = 0; cycle();
        chk("ready_after_rst", obs_ready, 1);
        chk("cnt_after_rst", obs_cnt, 0);

        // 1G back-to-back, then drop valid mid-frame
        send(8'hA5, 1, 0); cycle();
        chk("g1_latency", obs_rise, IDLE_Q);
        send(8'h3C, 1, 0); cycle();
        chk("g1_w0", {obs_rise, obs_fall}, 8'h5A);
        chk("g1_w0_ctl", {obs_cr, obs_cf}, 2'b11);
        in_valid = 0; cycle();
        chk("g1_w1", {obs_rise, obs_fall}, 8'hC3);
        chk("g1_no_early_urun", obs_urun, 0);
        cycle();
        chk("urun_pulse", obs_urun, 1);
        chk("urun_cnt1", obs_cnt, 1);
        chk("urun_idle", {obs_rise, obs_fall}, {IDLE_Q, IDLE_Q});
        cycle();
        chk("urun_one_cycle", obs_urun, 0);

        // 10/100 nibble replication
        spd_1g = 0; cycle();
        send(8'hA5, 1, 1); cycle();
        chk("m10_ready_idle", obs_ready, 1);
        in_valid = 0; cycle();
        chk("m10_ready_lo", obs_ready, 0);
        chk("m10_lo", {obs_rise, obs_fall}, 8'h55);
        chk("m10_lo_ctl", {obs_cr, obs_cf}, 2'b10);
        cycle();
        chk("m10_hi", {obs_rise, obs_fall}, 8'hAA);
        chk("m10_hi_ctl", {obs_cr, obs_cf}, 2'b10);
        cycle();
        chk("m10_urun", obs_urun, 1);
        chk("m10_cnt2", obs_cnt, 2);

        // Three more underruns: counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            send(8'h5A, 1, 0); cycle();
            in_valid = 0; cycle(); cycle(); cycle();
        end
        chk("cnt_sat", obs_cnt, 3);

        // CE freeze mid-frame in 1G
        spd_1g = 1; cycle();
        send(8'h21, 1, 0); cycle();
        send(8'h43, 1, 0); cycle();
        send(8'h65, 1, 0); cycle();
        chk("ce_pre", {obs_rise, obs_fall}, 8'h34);
        send(8'h87, 1, 0); CE = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ce_hold", {obs_rise, obs_fall}, 8'h34);
            chk("ce_no_ready", obs_ready, 0);
            chk("ce_no_urun", obs_urun, 0);
        end
        CE = 1; cycle();
        chk("ce_resume", {obs_rise, obs_fall}, 8'h56);
        send(8'hA9, 1, 0); cycle();
        chk("ce_resume2", {obs_rise, obs_fall}, 8'h78);
        in_valid = 0; cycle(); cycle();

        // Mode toggle mid-frame is deferred until a word with en=0
        send(8'h96, 1, 0); cycle();
        spd_1g = 0; send(8'hB4, 1, 0); cycle();
        send(8'hE1, 0, 0); cycle();
        chk("defer_1g", {obs_rise, obs_fall}, 8'h4B);
        send(8'hD2, 1, 0); cycle();
        chk("end_frame", {obs_rise, obs_fall}, 8'h1E);
        chk("end_frame_ctl", {obs_cr, obs_cf}, 2'b00);
        in_valid = 0; cycle();
        chk("switched_ready", obs_ready, 0);
        chk("switched_lo", {obs_rise, obs_fall}, 8'h22);
        cycle(); cycle();

        // Reset while in LO truncates the frame silently
        send(8'h77, 1, 0); cycle();
        in_valid = 0; R = 1; cycle();
        chk("rst_lo_q", {obs_rise, obs_fall}, {IDLE_Q, IDLE_Q});
        chk("rst_lo_ctl", {obs_cr, obs_cf}, 2'b00);
        R = 0; cycle();
        chk("rst_lo_ready", obs_ready, 1);
        chk("rst_lo_idle", obs_rise, IDLE_Q);
        chk("rst_lo_no_urun", obs_urun, 0);
        chk("rst_lo_cnt", obs_cnt, 0);

        for (int n = 0; n < 1500; n++) begin
            R        = ($urandom_range(0, 199) == 0);
            CE       = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 5) != 0);
            in_d     = (2*LANES)'($urandom);
            in_en    = ($urandom_range(0, 5) != 0);
            in_er    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) spd_1g = ~spd_1g;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
